// File: rtl/pattern_sequencer.sv
// Timeline-driven pattern generator: NUM_CH channels gated by two programmable
// windows over a shared step counter, with a blink prescaler and start/done handshake.
module pattern_sequencer #(
    parameter int NUM_CH  = 12,
    parameter int CNT_W   = 8,
    parameter int DIV_W   = 4,
    parameter int END_CNT = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIV_W-1:0]      div,
    input  logic [2*NUM_CH-1:0]   ch_mode,
    input  logic [NUM_CH-1:0]     ch_grp,
    input  logic [CNT_W-1:0]      win_a_lo,
    input  logic [CNT_W-1:0]      win_a_hi,
    input  logic [CNT_W-1:0]      win_b_lo,
    input  logic [CNT_W-1:0]      win_b_hi,
    output logic [NUM_CH-1:0]     signals,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      step_cnt
);

    localparam logic [CNT_W-1:0] END_V  = CNT_W'(END_CNT);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(END_CNT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DIV_W-1:0]   pre_q;
    logic [DIV_W-1:0]   div_q;
    logic               phase_q;
    logic [NUM_CH-1:0]  signals_q;
    logic               busy_q;
    logic               done_q;

    logic               hit_a;
    logic               hit_b;
    logic [NUM_CH-1:0]  signals_d;

    // An inverted window (lo > hi) can never satisfy both bounds, so it stays empty.
    assign hit_a = (win_a_lo <= cnt_q) && (cnt_q <= win_a_hi);
    assign hit_b = (win_b_lo <= cnt_q) && (cnt_q <= win_b_hi);

    always_comb begin
        signals_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((state_q == RUN) && (ch_grp[i] ? hit_b : hit_a)) begin
                case (ch_mode[2*i +: 2])
                    2'b00:   signals_d[i] = 1'b0;
                    2'b01:   signals_d[i] = 1'b1;
                    2'b10:   signals_d[i] = phase_q;
                    default: signals_d[i] = ~phase_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pre_q     <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            signals_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            signals_q <= signals_d;
            done_q    <= 1'b0;
            if (start) begin
                // Restart takes priority over a coincident final step: no done pulse.
                state_q <= RUN;
                cnt_q   <= '0;
                pre_q   <= '0;
                phase_q <= 1'b0;
                div_q   <= div;
                busy_q  <= 1'b1;
            end else if (state_q == RUN) begin
                if (pre_q != div_q) begin
                    pre_q <= pre_q + DIV_W'(1);
                end else begin
                    pre_q   <= '0;
                    phase_q <= ~phase_q;
                    if (cnt_q == LAST_V) begin
                        cnt_q   <= END_V;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign signals  = signals_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_cnt = cnt_q;

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Parametrised successor to the fixed 12-channel blink/cross generator. It drives NUM_CH pattern outputs from a shared timeline counter and a programmable blink prescaler. Each channel has a run-time mode (off / solid / blink / inverted blink) and a choice of one of two time windows. A start/done handshake lets the top level sequence successive patterns (cross, heart, etc.) without re-asserting reset.

## Interface
Parameters:
- NUM_CH, 12, number of pattern output channels
- CNT_W, 8, timeline counter width
- DIV_W, 4, blink prescaler width
- END_CNT, 60, timeline length in steps; must be ≤ 2^CNT_W − 1

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; overrides every other input
- start  in  1  pulse; (re)starts the timeline from step 0
- div  in  DIV_W  step period minus one (step every div+1 cycles); sampled only when start is accepted
- ch_mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 solid, 10 blink, 11 inverted blink; live
- ch_grp  in  NUM_CH  per-channel window select: 0 = window A, 1 = window B; live
- win_a_lo, win_a_hi  in  CNT_W each  window A inclusive bounds; live
- win_b_lo, win_b_hi  in  CNT_W each  window B inclusive bounds; live
- signals  out  NUM_CH  registered pattern outputs
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse when the timeline completes
- step_cnt  out  CNT_W  current timeline counter value

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE with counter = 0, prescaler = 0, phase = 0, div_q = 0, signals = 0, busy = 0, done = 0.
- IDLE/DONE + start: go to RUN. Set counter = 0, prescaler = 0, phase = 0, div_q = div.
- RUN, prescaler ≠ div_q: prescaler + 1.
- RUN, prescaler == div_q (a step): prescaler = 0, phase toggles, counter + 1.
  - If counter was END_CNT−1, the counter saturates at END_CNT, the state goes to DONE and done = 1 for that one cycle.
- RUN + start: restart exactly as from IDLE. Counter, prescaler and phase are cleared and div is re-sampled. done is not pulsed.
- DONE: holds the counter at END_CNT. Only start or reset leave this state.
- Window hit for channel i: lo ≤ counter ≤ hi, using the selected group. When lo > hi the window is empty and never hits.
- Next value of signals[i]:
  - If state ≠ RUN or no window hit: 0.
  - Otherwise by mode: off → 0; solid → 1; blink → phase; inverted blink → ~phase.
- Mode and window inputs are not latched. A change takes effect on the next registered output.
- All compares are unsigned, CNT_W wide. The prescaler compare is DIV_W wide.

## Timing
- start high at edge T → busy = 1 and counter = 0 after T. signals reflect (counter 0, phase 0) after edge T+1. Output latency from state to pins is 1 cycle.
- With div = 0, phase toggles and the counter advances every cycle. This is equivalent to the legacy blink rate.
- With div = d, each step lasts d+1 cycles. The total run is END_CNT·(d+1) cycles from start acceptance to the done pulse.
- done and the busy fall occur together on the edge where the counter reaches END_CNT.
  - signals still show the step END_CNT−1 values for that one cycle, then go to 0 on the following edge.
- reset + start on the same edge: reset wins, state is IDLE.
- Reset asserted mid-RUN: all outputs take their reset values on that edge. No done pulse.
- start in the same cycle as the final step: the restart wins. No done pulse; counter = 0.

## Test plan
- Legacy cross: NUM_CH=12, END_CNT=60, div=0. Channels 2–5 blink on window A [0,59]; all other channels blink on window B [20,40]. Required response:
  - ch2–5 alternate 0/1 for 60 cycles.
  - The other channels toggle only while step_cnt is in 20..40.
  - done pulses once, 60 cycles after start; all signals are 0 afterwards.
- Prescaler: div=3, one channel in solid mode, window [0,59] → output high for 240 cycles. With blink mode, phase half-period is 4 cycles. done fires at cycle 240.
- Modes: four channels set to off / solid / blink / inverted on the same window → 0, 1, phase, ~phase. Blink and inverted outputs are never equal.
- Windows: lo=hi=10 → exactly one step high. lo=30, hi=20 → never high. hi=END_CNT−1 → high through the last step.
- Restart: start reasserted at step 25 → counter returns to 0, no done pulse. The new div value takes effect; the old one is ignored.
- Reset mid-run at step 33 → signals, busy and done are 0 on that edge, state IDLE. A later start runs the full 60 steps normally.
